mu0_control: RTL and testbench

Control unit for the MU0 16-bit processor. A two-state fetch/execute sequencer plus a halt state. It drives the enables of the three 16-bit MU0 registers (ACC, PC, IR), the datapath multiplexer selects, the ALU function code and the memory strobes. Opcode and flags come back from the datapath. It sits beside the datapath in the MU0 top level, and every register update in the processor is gated by its outputs.

---
 rtl/mu0_pkg.sv | 23 ++
 rtl/mu0_control.sv | 90 +++++++++
 tb/tb_mu0_control.sv | 165 ++++++++++++++++
 3 files changed

// File: rtl/mu0_pkg.sv
// MU0 shared constants: sequencer state encoding,
// opcodes and ALU function codes.
package mu0_pkg;

  localparam logic [1:0] S_FETCH   = 2'b00;
  localparam logic [1:0] S_EXECUTE = 2'b01;
  localparam logic [1:0] S_HALT    = 2'b10;

  localparam logic [3:0] OP_LDA = 4'h0;
  localparam logic [3:0] OP_STA = 4'h1;
  localparam logic [3:0] OP_ADD = 4'h2;
  localparam logic [3:0] OP_SUB = 4'h3;
  localparam logic [3:0] OP_JMP = 4'h4;
  localparam logic [3:0] OP_JGE = 4'h5;
  localparam logic [3:0] OP_JNE = 4'h6;
  localparam logic [3:0] OP_STP = 4'h7;

  localparam logic [1:0] M_PASSY = 2'b00;
  localparam logic [1:0] M_ADD   = 2'b01;
  localparam logic [1:0] M_INC   = 2'b10;
  localparam logic [1:0] M_SUB   = 2'b11;

endpackage

// File: rtl/mu0_control.sv
// MU0 control unit: fetch/execute/halt sequencer
// with combinational decode of register enables and strobes.
module mu0_control
  import mu0_pkg::*;
(
  input  logic       Clk,
  input  logic       Reset,
  input  logic [3:0] F,
  input  logic       N,
  input  logic       Z,
  output logic       X_sel,
  output logic       Y_sel,
  output logic       Addr_sel,
  output logic       PC_En,
  output logic       IR_En,
  output logic       Acc_En,
  output logic [1:0] M,
  output logic       Rd,
  output logic       Wr,
  output logic       Halted
);

  logic [1:0] state;
  logic [1:0] state_nxt;

  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset) state <= S_FETCH;
    else        state <= state_nxt;
  end

  // Reset gates the decode so outputs drop without a clock edge.
  always_comb begin
    X_sel     = 1'b0;
    Y_sel     = 1'b0;
    Addr_sel  = 1'b0;
    PC_En     = 1'b0;
    IR_En     = 1'b0;
    Acc_En    = 1'b0;
    M         = M_PASSY;
    Rd        = 1'b0;
    Wr        = 1'b0;
    Halted    = 1'b0;
    state_nxt = S_FETCH;
    if (Reset) begin
      case (state)
        S_FETCH: begin
          Rd        = 1'b1;
          IR_En     = 1'b1;
          PC_En     = 1'b1;
          M         = M_INC;
          state_nxt = S_EXECUTE;
        end
        S_EXECUTE: begin
          case (F)
            OP_LDA: begin
              Addr_sel = 1'b1;
              Rd       = 1'b1;
              Y_sel    = 1'b1;
              Acc_En   = 1'b1;
            end
            OP_STA: begin
              Addr_sel = 1'b1;
              Wr       = 1'b1;
              X_sel    = 1'b1;
            end
            OP_ADD, OP_SUB: begin
              Addr_sel = 1'b1;
              Rd       = 1'b1;
              X_sel    = 1'b1;
              Y_sel    = 1'b1;
              Acc_En   = 1'b1;
              M        = (F == OP_ADD) ? M_ADD : M_SUB;
            end
            OP_JMP: PC_En = 1'b1;
            OP_JGE: PC_En = ~N;
            OP_JNE: PC_En = ~Z;
            OP_STP: state_nxt = S_HALT;
            default: ;
          endcase
        end
        S_HALT: begin
          Halted    = 1'b1;
          state_nxt = S_HALT;
        end
        default: state_nxt = S_FETCH;
      endcase
    end
  end

endmodule

// File: tb/tb_mu0_control.sv
// Scoreboard bench for mu0_control: driver pushes model
// expectations, negedge monitor pops and compares.
module tb_mu0_control;

  logic       Clk = 1'b0;
  logic       Reset = 1'b0;
  logic [3:0] F = 4'h0;
  logic       N = 1'b0;
  logic       Z = 1'b0;
  logic       X_sel, Y_sel, Addr_sel, PC_En, IR_En, Acc_En;
  logic [1:0] M;
  logic       Rd, Wr, Halted;

  mu0_control dut (
    .Clk(Clk), .Reset(Reset), .F(F), .N(N), .Z(Z),
    .X_sel(X_sel), .Y_sel(Y_sel), .Addr_sel(Addr_sel),
    .PC_En(PC_En), .IR_En(IR_En), .Acc_En(Acc_En),
    .M(M), .Rd(Rd), .Wr(Wr), .Halted(Halted)
  );

  always #5 Clk = ~Clk;

  typedef struct {
    logic [10:0] v;
    int          id;
  } exp_t;

  exp_t q[$];
  int total = 0;
  int bad = 0;
  int seq = 0;

  // model: in_exec = second cycle of an instruction, halted = stopped
  bit in_exec = 0, halted = 0;
  bit nx_exec = 0, nx_halt = 0;

  function automatic logic [10:0] pack(
    bit x, bit y, bit a, bit pc, bit ir, bit acc,
    int m, bit rd, bit wr, bit h);
    logic [1:0] mm;
    mm = 2'(m);
    return {x, y, a, pc, ir, acc, mm, rd, wr, h};
  endfunction

  function automatic logic [10:0] model(
    bit rst_n, bit ex, bit hl, int f, bit n, bit z);
    bit reads, writes, jump;
    int m;
    if (!rst_n) return '0;
    if (hl) return pack(0,0,0,0,0,0,0,0,0,1);
    if (!ex) return pack(0,0,0,1,1,0,2,1,0,0);
    reads  = (f == 0) || (f == 2) || (f == 3);
    writes = (f == 1);
    jump   = (f == 4) || (f == 5 && !n) || (f == 6 && !z);
    m = (f == 2) ? 1 : (f == 3) ? 3 : 0;
    return pack(f >= 1 && f <= 3, reads, reads || writes,
                jump, 0, reads, m, reads, writes, 0);
  endfunction

  function automatic logic [10:0] dut_vec();
    return {X_sel, Y_sel, Addr_sel, PC_En, IR_En, Acc_En,
            M, Rd, Wr, Halted};
  endfunction

  task automatic cycle(bit r, int f, bit n, bit z);
    exp_t e;
    @(posedge Clk);
    in_exec = nx_exec;
    halted  = nx_halt;
    #1;
    Reset = r;
    F = 4'(f);
    N = n;
    Z = z;
    if (!r) begin
      in_exec = 0;
      halted  = 0;
    end
    e.v  = model(r, in_exec, halted, f, n, z);
    e.id = seq++;
    q.push_back(e);
    if (!r) begin
      nx_exec = 0;
      nx_halt = 0;
    end else begin
      nx_halt = halted || (in_exec && f == 7);
      nx_exec = !halted && !in_exec;
    end
  endtask

  task automatic instr(int f, bit n, bit z);
    cycle(1, $urandom_range(0, 15), $urandom_range(0, 1),
          $urandom_range(0, 1));
    cycle(1, f, n, z);
  endtask

  always @(negedge Clk) begin
    exp_t e;
    if (q.size() > 0) begin
      e = q.pop_front();
      total++;
      if (dut_vec() !== e.v) begin
        bad++;
        $display("FAIL outputs#%0d got=%b want=%b F=%h N=%b Z=%b",
                 e.id, dut_vec(), e.v, F, N, Z);
      end
    end
  end

  initial begin
    cycle(0, 0, 0, 0);
    cycle(0, 5, 1, 1);
    cycle(1, 3, 0, 0);
    cycle(1, 0, 0, 0);
    instr(1, 0, 0);
    instr(2, 0, 0);
    instr(3, 1, 1);
    instr(5, 1, 0);
    instr(5, 0, 1);
    instr(6, 0, 1);
    instr(6, 1, 0);
    instr(4, 1, 1);
    instr(9, 0, 0);
    instr(15, 1, 1);
    instr(7, 0, 0);
    for (int i = 0; i < 16; i++) cycle(1, i, i[0], i[1]);
    cycle(0, 0, 0, 0);
    cycle(1, 0, 0, 0);

    // abort LDA mid-execute
    cycle(1, 0, 0, 0);
    @(negedge Clk);
    #1;
    Reset = 1'b0;
    #1;
    total++;
    if (dut_vec() !== 11'b0) begin
      bad++;
      $display("FAIL async_abort got=%b want=%b", dut_vec(), 11'b0);
    end
    nx_exec = 0;
    nx_halt = 0;
    cycle(0, 0, 0, 0);
    cycle(1, 0, 0, 0);

    for (int i = 0; i < 400; i++) begin
      if ($urandom_range(0, 49) == 0 || (halted && $urandom_range(0, 7) == 0))
        cycle(0, $urandom_range(0, 15), $urandom_range(0, 1),
              $urandom_range(0, 1));
      else
        cycle(1, $urandom_range(0, 15), $urandom_range(0, 1),
              $urandom_range(0, 1));
    end

    repeat (2) @(posedge Clk);
    total++;
    if (q.size() != 0) begin
      bad++;
      $display("FAIL queue_drain got=%0d want=0", q.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
